// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_if
// Purpose  : Operand / result handshake bundle for serial_subtractor.
//            master = producer/consumer side, slave = the subtractor.
//            Carries the ovf flag only when SUB_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             busy;
`ifdef SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero, busy
`ifdef SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero, busy
`ifdef SUB_OVF_EN
        , output ovf
`endif
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Multi-cycle subtractor, diff = a - b - bin over WIDTH bits,
//            DIGIT bits per clock, LSB chunk first, borrow kept in a register.
//            Valid/ready handshake on both sides, all outputs registered.
//            Optional macro SUB_OVF_EN adds the signed-overflow flag ovf.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Reject configurations that cannot split into whole chunks.
    generate
        if ((DIGIT < 1) || (WIDTH < 2) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
            $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       r_state;
    // r_acc starts as the minuend; each step consumes its low chunk and the
    // result chunk enters at the top, so after STEPS steps it holds diff.
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_zero;
    logic             r_busy;
`ifdef SUB_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ovf;
    logic             w_ovf;
`endif

    logic [DIGIT:0]   w_t;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_b_next;
    logic             w_last;

    // One chunk of the subtraction; the extra top bit is the borrow out.
    assign w_t = {1'b0, r_acc[DIGIT-1:0]}
               - {1'b0, r_b_sh[DIGIT-1:0]}
               - {{DIGIT{1'b0}}, r_borrow};

    generate
        if (DIGIT == WIDTH) begin : g_single
            assign w_acc_next = w_t[DIGIT-1:0];
            assign w_b_next   = '0;
        end else begin : g_multi
            assign w_acc_next = {w_t[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};
            assign w_b_next   = {{DIGIT{1'b0}}, r_b_sh[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign w_last = (r_cnt == CW'(STEPS - 1));

`ifdef SUB_OVF_EN
    // Operands of opposite sign and a result whose sign differs from a.
    assign w_ovf = (r_a_msb ^ r_b_msb) & (w_acc_next[WIDTH-1] ^ r_a_msb);
`endif

    // Control FSM plus datapath: accept, shift chunk by chunk, hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_b_sh      <= '0;
            r_borrow    <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_zero      <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SUB_OVF_EN
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_acc      <= bus.a;
                        r_b_sh     <= bus.b;
                        r_borrow   <= bus.bin;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_CALC;
`ifdef SUB_OVF_EN
                        r_a_msb    <= bus.a[WIDTH-1];
                        r_b_msb    <= bus.b[WIDTH-1];
`endif
                    end
                end
                S_CALC: begin
                    r_acc    <= w_acc_next;
                    r_b_sh   <= w_b_next;
                    r_borrow <= w_t[DIGIT];
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_diff      <= w_acc_next;
                        r_bout      <= w_t[DIGIT];
                        r_zero      <= (w_acc_next == '0);
`ifdef SUB_OVF_EN
                        r_ovf       <= w_ovf;
`endif
                    end
                end
                S_DONE: begin
                    // in_ready returns only after the output handshake edge,
                    // so no new operand can be taken in the same cycle.
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;
    assign bus.zero      = r_zero;
    assign bus.busy      = r_busy;
`ifdef SUB_OVF_EN
    assign bus.ovf       = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor. Four instances
//            (DIGIT = 1, 2, 4, 16; WIDTH = 16) share one stimulus stream and
//            are compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;
    localparam int W = 16;
    localparam int N = 4;

    function automatic int digit_of(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 16;
        endcase
    endfunction

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_ready;

    logic [N-1:0] ov, ir, bo, zr, bz;
    logic [W-1:0] df [N];
`ifdef SUB_OVF_EN
    logic [N-1:0] vf;
`endif

    int n_checks = 0;
    int n_err    = 0;

    logic [W-1:0] e_d;
    logic         e_bo;
    logic         e_z;
    logic         e_v;

    always #5 clk = ~clk;

    generate
        for (genvar k = 0; k < N; k++) begin : g_dut
            serial_subtractor_if #(.WIDTH(W)) u_if ();
            assign u_if.in_valid  = in_valid;
            assign u_if.a         = a;
            assign u_if.b         = b;
            assign u_if.bin       = bin;
            assign u_if.out_ready = out_ready;
            assign ov[k] = u_if.out_valid;
            assign ir[k] = u_if.in_ready;
            assign bo[k] = u_if.bout;
            assign zr[k] = u_if.zero;
            assign bz[k] = u_if.busy;
            assign df[k] = u_if.diff;
`ifdef SUB_OVF_EN
            assign vf[k] = u_if.ovf;
`endif
            serial_subtractor #(.WIDTH(W), .DIGIT(digit_of(k))) u_dut (
                .clk   (clk),
                .rst_n (rst_n),
                .bus   (u_if)
            );
        end
    endgenerate

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        int ua, ub, c, r, sa, sb, sr;
        ua = int'(ma);
        ub = int'(mb);
        c  = mbin ? 1 : 0;
        r  = ua - ub - c;
        e_d  = r[W-1:0];
        e_bo = (ua < ub + c);
        e_z  = (e_d == '0);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        sr = sa - sb - c;
        e_v = (sr > 32767) || (sr < -32768);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic expect_reset(input string tag);
        for (int k = 0; k < N; k++) begin
            chk({tag, ".out_valid"}, k, 32'(ov[k]), 32'd0);
            chk({tag, ".in_ready"},  k, 32'(ir[k]), 32'd1);
            chk({tag, ".diff"},      k, 32'(df[k]), 32'd0);
            chk({tag, ".bout"},      k, 32'(bo[k]), 32'd0);
            chk({tag, ".zero"},      k, 32'(zr[k]), 32'd0);
            chk({tag, ".busy"},      k, 32'(bz[k]), 32'd0);
`ifdef SUB_OVF_EN
            chk({tag, ".ovf"},       k, 32'(vf[k]), 32'd0);
`endif
        end
    endtask

    task automatic start_op(input logic [W-1:0] sa, input logic [W-1:0] sb, input logic sbin);
        model(sa, sb, sbin);
        in_valid = 1'b1;
        a = sa;
        b = sb;
        bin = sbin;
        step();
        in_valid = 1'b0;
        a   = W'($urandom);
        b   = W'($urandom);
        bin = 1'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int lat [N];
        for (int k = 0; k < N; k++) lat[k] = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            for (int k = 0; k < N; k++)
                if (ov[k] && lat[k] == 0) lat[k] = c;
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && lat[3] != 0) break;
        end
        for (int k = 0; k < N; k++)
            chk({tag, ".latency"}, k, 32'(lat[k]), 32'(W / digit_of(k)));
    endtask

    task automatic check_result(input string tag);
        for (int k = 0; k < N; k++) begin
            chk({tag, ".out_valid"}, k, 32'(ov[k]), 32'd1);
            chk({tag, ".diff"},      k, 32'(df[k]), 32'(e_d));
            chk({tag, ".bout"},      k, 32'(bo[k]), 32'(e_bo));
            chk({tag, ".zero"},      k, 32'(zr[k]), 32'(e_z));
            chk({tag, ".busy"},      k, 32'(bz[k]), 32'd1);
            chk({tag, ".in_ready"},  k, 32'(ir[k]), 32'd0);
`ifdef SUB_OVF_EN
            chk({tag, ".ovf"},       k, 32'(vf[k]), 32'(e_v));
`endif
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk({tag, ".hs_out_valid"}, k, 32'(ov[k]), 32'd0);
            chk({tag, ".hs_in_ready"},  k, 32'(ir[k]), 32'd1);
            chk({tag, ".hs_busy"},      k, 32'(bz[k]), 32'd0);
            chk({tag, ".hs_diff_kept"}, k, 32'(df[k]), 32'(e_d));
        end
    endtask

    task automatic run_op(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbin, input string tag);
        start_op(ra, rb, rbin);
        wait_done(tag);
        check_result(tag);
        handshake(tag);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_reset("reset");
        rst_n = 1'b1;
        step();
        expect_reset("idle");

        // Directed arithmetic cases
        run_op(16'h1234, 16'h0234, 1'b0, "basic");
        run_op(16'h0000, 16'h0001, 1'b0, "wrap");
        run_op(16'h0005, 16'h0004, 1'b1, "zero");
        run_op(16'h0000, 16'h0000, 1'b1, "all_ones");
        run_op(16'hABCD, 16'hABCD, 1'b0, "equal");

        // Backpressure: result held while new operands are offered
        start_op(16'hA5A5, 16'h5A5A, 1'b1);
        wait_done("bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a   = W'($urandom);
            b   = W'($urandom);
            bin = 1'($urandom);
            step();
            check_result("bp_hold");
        end
        in_valid = 1'b0;
        handshake("bp");
        run_op(16'h8000, 16'h0001, 1'b0, "bp_next");

        // Reset in the middle of a computation
        start_op(16'hBEEF, 16'h1234, 1'b0);
        repeat (7) step();
        chk("midcalc.no_early_valid", 0, 32'(ov[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        expect_reset("midcalc_reset");
        step();
        rst_n = 1'b1;
        step();
        run_op(16'h00FF, 16'h000F, 1'b0, "post_reset");

`ifdef SUB_OVF_EN
        run_op(16'h7FFF, 16'hFFFF, 1'b0, "ovf_pos");
        run_op(16'h0000, 16'h7FFF, 1'b1, "ovf_neg_edge");
`endif

        // Randomized vectors against the model
        for (int i = 0; i < 1000; i++)
            run_op(pick(), pick(), 1'($urandom), "rand");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
